// File: rtl/ex_stage_pkg.sv
// Shared widths, bus layouts and bit indices for the MIPS execute stage.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD  = 38;
  localparam int STALL_WD     = 6;
  localparam int LOAD_WD      = 5;
  localparam int SAVE_WD      = 3;

  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  localparam int SRC1_DATA1 = 0;
  localparam int SRC1_PC    = 1;
  localparam int SRC1_SA    = 2;
  localparam int SRC2_DATA2 = 0;
  localparam int SRC2_SIMM  = 1;
  localparam int SRC2_EIGHT = 2;
  localparam int SRC2_ZIMM  = 3;

  localparam int SAVE_SW = 0;
  localparam int SAVE_SH = 1;
  localparam int SAVE_SB = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] data1;
    logic [31:0] data2;
  } id_to_ex_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Purely combinational ALU; one-hot alu_op, an all-zero op yields zero.
module alu
  import ex_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  logic [4:0] sa;
  assign sa = src1[4:0];

  always_comb begin
    result = '0;
    if (alu_op[OP_ADD])  result = result | (src1 + src2);
    if (alu_op[OP_SUB])  result = result | (src1 - src2);
    if (alu_op[OP_SLT])  result = result | {31'b0, $signed(src1) < $signed(src2)};
    if (alu_op[OP_SLTU]) result = result | {31'b0, src1 < src2};
    if (alu_op[OP_AND])  result = result | (src1 & src2);
    if (alu_op[OP_NOR])  result = result | ~(src1 | src2);
    if (alu_op[OP_OR])   result = result | (src1 | src2);
    if (alu_op[OP_XOR])  result = result | (src1 ^ src2);
    if (alu_op[OP_SLL])  result = result | (src2 << sa);
    if (alu_op[OP_SRL])  result = result | (src2 >> sa);
    if (alu_op[OP_SRA])  result = result | 32'($signed(src2) >>> sa);
    if (alu_op[OP_LUI])  result = result | {src2[15:0], 16'b0};
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID->EX input register, ALU, and data SRAM request generation.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  input  logic [4:0]   id_load_bus,
  input  logic [2:0]   id_save_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [4:0]   ex_load_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         pre_inst_is_load,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  id_to_ex_t   ex_q, ex_d;
  logic [4:0]  load_q, load_d;
  logic [2:0]  save_q, save_d;

  // A stalled EX with a moving MEM must emit a bubble, not a duplicate.
  always_comb begin
    ex_d   = ex_q;
    load_d = load_q;
    save_d = save_q;
    if (stall[STALL_EX] && !stall[STALL_MEM]) begin
      ex_d   = '0;
      load_d = '0;
      save_d = '0;
    end else if (!stall[STALL_EX]) begin
      ex_d   = id_to_ex_t'(id_to_ex_bus);
      load_d = id_load_bus;
      save_d = id_save_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      load_q <= '0;
      save_q <= '0;
    end else begin
      ex_q   <= ex_d;
      load_q <= load_d;
      save_q <= save_d;
    end
  end

  logic [31:0] src1, src2, ex_result;

  always_comb begin
    src1 = '0;
    if (ex_q.sel_src1[SRC1_DATA1]) src1 = src1 | ex_q.data1;
    if (ex_q.sel_src1[SRC1_PC])    src1 = src1 | ex_q.pc;
    if (ex_q.sel_src1[SRC1_SA])    src1 = src1 | {27'b0, ex_q.inst[10:6]};
    src2 = '0;
    if (ex_q.sel_src2[SRC2_DATA2]) src2 = src2 | ex_q.data2;
    if (ex_q.sel_src2[SRC2_SIMM])  src2 = src2 | {{16{ex_q.inst[15]}}, ex_q.inst[15:0]};
    if (ex_q.sel_src2[SRC2_EIGHT]) src2 = src2 | 32'd8;
    if (ex_q.sel_src2[SRC2_ZIMM])  src2 = src2 | {16'b0, ex_q.inst[15:0]};
  end

  alu u_alu (
    .alu_op (ex_q.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (ex_result)
  );

  logic [1:0]  lane;
  logic [3:0]  lane_wen;
  logic [31:0] lane_wdata;

  // Stores replicate data across lanes; misaligned sw is deliberately not trapped.
  always_comb begin
    lane       = ex_result[1:0];
    lane_wen   = 4'b0000;
    lane_wdata = ex_q.data2;
    if (save_q[SAVE_SB]) begin
      lane_wen   = 4'b0001 << lane;
      lane_wdata = {4{ex_q.data2[7:0]}};
    end else if (save_q[SAVE_SH]) begin
      lane_wen   = lane[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{ex_q.data2[15:0]}};
    end else if (save_q[SAVE_SW]) begin
      lane_wen   = 4'b1111;
      lane_wdata = ex_q.data2;
    end
  end

  assign data_sram_en     = ex_q.ram_en;
  assign data_sram_wen    = lane_wen;
  assign data_sram_addr   = ex_result;
  assign data_sram_wdata  = lane_wdata;
  assign ex_load_bus      = load_q;
  assign pre_inst_is_load = |load_q;
  assign ex_to_rf_bus     = {ex_q.rf_we, ex_q.rf_waddr, ex_result};
  assign ex_to_mem_bus    = {ex_q.pc, ex_q.ram_en, lane_wen, ex_q.sel_rf_res,
                             ex_q.rf_we, ex_q.rf_waddr, ex_result};

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], ex_q.inst[31:16], ex_q.ram_wen};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a behavioural model.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [4:0]   id_load_bus;
  logic [2:0]   id_save_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [4:0]   ex_load_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         pre_inst_is_load;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_vec = 0;
  int n_err = 0;

  logic [158:0] m_bus;
  logic [4:0]   m_load;
  logic [2:0]   m_save;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .id_to_ex_bus     (id_to_ex_bus),
    .id_load_bus      (id_load_bus),
    .id_save_bus      (id_save_bus),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .ex_load_bus      (ex_load_bus),
    .ex_to_rf_bus     (ex_to_rf_bus),
    .pre_inst_is_load (pre_inst_is_load),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata)
  );

  function automatic logic [158:0] mk_bus(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
    input logic rf_we, input logic [4:0] waddr, input logic selres,
    input logic [31:0] d1, input logic [31:0] d2);
    return {pc, inst, op, s1, s2, ram_en, 4'b0, rf_we, waddr, selres, d1, d2};
  endfunction

  // Expected outputs straight from the instruction semantics.
  function automatic logic [188:0] model(input logic [158:0] b, input logic [4:0] ld,
                                         input logic [2:0] sv);
    logic [31:0] pc, inst, d1, d2, a, c, r, wd;
    logic [11:0] op;
    logic [3:0]  wen;
    int unsigned sh;
    pc = b[158:127]; inst = b[126:95]; op = b[94:83];
    d1 = b[63:32];   d2 = b[31:0];
    case (b[82:80])
      3'b001:  a = d1;
      3'b010:  a = pc;
      3'b100:  a = {27'b0, inst[10:6]};
      default: a = 0;
    endcase
    case (b[79:76])
      4'b0001: c = d2;
      4'b0010: c = {{16{inst[15]}}, inst[15:0]};
      4'b0100: c = 8;
      4'b1000: c = {16'b0, inst[15:0]};
      default: c = 0;
    endcase
    sh = a % 32;
    case (op)
      12'h001: r = a + c;
      12'h002: r = a - c;
      12'h004: r = (int'(a) < int'(c)) ? 1 : 0;
      12'h008: r = (longint'(a) < longint'(c)) ? 1 : 0;
      12'h010: r = a & c;
      12'h020: r = ~(a | c);
      12'h040: r = a | c;
      12'h080: r = a ^ c;
      12'h100: r = c * (32'd1 << sh);
      12'h200: r = c / (32'd1 << sh);
      12'h400: r = (c / (32'd1 << sh)) | (c[31] ? ~(32'hFFFF_FFFF / (32'd1 << sh)) : 32'd0);
      12'h800: r = c * 65536;
      default: r = 0;
    endcase
    wen = 0; wd = d2;
    if (sv == 3'b100) begin
      wen = 4'(1 << (r % 4)); wd = {4{d2[7:0]}};
    end else if (sv == 3'b010) begin
      wen = (r % 4 >= 2) ? 4'hC : 4'h3; wd = {2{d2[15:0]}};
    end else if (sv == 3'b001) begin
      wen = 4'hF;
    end
    return {pc, b[75], wen, b[64], b[70], b[69:65], r,
            ld, b[70], b[69:65], r, (ld != 0), b[75], wen, r, wd};
  endfunction

  function automatic logic [188:0] observed();
    return {ex_to_mem_bus, ex_load_bus, ex_to_rf_bus, pre_inst_is_load,
            data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_bus = '0; m_load = '0; m_save = '0;
    end else if (stall[2] && !stall[3]) begin
      m_bus = '0; m_load = '0; m_save = '0;
    end else if (!stall[2]) begin
      m_bus = id_to_ex_bus; m_load = id_load_bus; m_save = id_save_bus;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0;
    id_to_ex_bus = mk_bus(32'h40, 32'h1234, 12'h001, 3'b001, 4'b0001, 1, 1, 7, 1, 5, 6);
    id_load_bus = 5'b00001; id_save_bus = 3'b001;
    tick(); tick();
    n_vec++;
    if (observed() !== 189'b0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", observed());
    end
    rst = 0;
  endtask

  task automatic test_addiu();
    id_to_ex_bus = mk_bus(32'hBFC0_0000, 32'h2485_FFFF, 12'h001, 3'b001, 4'b0010, 0, 1, 5, 0,
                          32'h0000_0010, 32'h0);
    id_load_bus = 0; id_save_bus = 0;
    tick();
    n_vec++;
    if (ex_to_rf_bus !== {1'b1, 5'd5, 32'h0000_000F} || data_sram_en !== 1'b0) begin
      n_err++; $display("FAIL addiu: rf_bus %h en %b want %h en 0", ex_to_rf_bus, data_sram_en,
                        {1'b1, 5'd5, 32'h0000_000F});
    end
  endtask

  task automatic test_shift();
    id_to_ex_bus = mk_bus(32'h0, 32'h0000_0100, 12'h100, 3'b100, 4'b0001, 0, 1, 3, 0,
                          32'h0, 32'h8000_0001);
    tick();
    n_vec++;
    if (data_sram_addr !== 32'h0000_0010) begin
      n_err++; $display("FAIL sll: got %h want 00000010", data_sram_addr);
    end
    id_to_ex_bus = mk_bus(32'h0, 32'h0000_0100, 12'h400, 3'b100, 4'b0001, 0, 1, 3, 0,
                          32'h0, 32'h8000_0000);
    tick();
    n_vec++;
    if (data_sram_addr !== 32'hF800_0000) begin
      n_err++; $display("FAIL sra: got %h want f8000000", data_sram_addr);
    end
  endtask

  task automatic test_store();
    id_to_ex_bus = mk_bus(32'h0, 32'h0, 12'h001, 3'b001, 4'b0010, 1, 0, 0, 0,
                          32'h1003, 32'h0000_00AB);
    id_save_bus = 3'b100;
    tick();
    n_vec++;
    if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}
        !== {1'b1, 4'b1000, 32'h1003, 32'hABAB_ABAB}) begin
      n_err++; $display("FAIL sb: en %b wen %b addr %h wdata %h want 1 1000 1003 ababab",
                        data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
    end
    id_to_ex_bus = mk_bus(32'h0, 32'h0, 12'h001, 3'b001, 4'b0010, 1, 0, 0, 0,
                          32'h1002, 32'h0000_CDAB);
    id_save_bus = 3'b010;
    tick();
    n_vec++;
    if (data_sram_wen !== 4'b1100 || data_sram_wdata !== 32'hCDAB_CDAB
        || ex_to_mem_bus[42:39] !== 4'b1100) begin
      n_err++; $display("FAIL sh: wen %b wdata %h lane %b want 1100 cdabcdab",
                        data_sram_wen, data_sram_wdata, ex_to_mem_bus[42:39]);
    end
    id_save_bus = 0;
  endtask

  task automatic test_load();
    id_to_ex_bus = mk_bus(32'h0, 32'h0, 12'h001, 3'b001, 4'b0010, 1, 1, 9, 1, 32'h2000, 32'h0);
    id_load_bus = 5'b00001;
    tick();
    n_vec++;
    if (pre_inst_is_load !== 1'b1 || ex_load_bus !== 5'b00001 || ex_to_mem_bus[38] !== 1'b1
        || data_sram_wen !== 4'b0 || data_sram_en !== 1'b1) begin
      n_err++; $display("FAIL lw: load %b bus %b selres %b wen %b en %b", pre_inst_is_load,
                        ex_load_bus, ex_to_mem_bus[38], data_sram_wen, data_sram_en);
    end
    id_to_ex_bus = '0; id_load_bus = 0;
    tick();
    n_vec++;
    if (pre_inst_is_load !== 1'b0) begin
      n_err++; $display("FAIL nop_after_lw: load %b want 0", pre_inst_is_load);
    end
  endtask

  task automatic test_stall();
    logic [188:0] held;
    id_to_ex_bus = mk_bus(32'h80, 32'h0, 12'h001, 3'b001, 4'b0010, 1, 0, 0, 0,
                          32'h3000, 32'h1122_3344);
    id_save_bus = 3'b001;
    tick();
    held = observed();
    n_vec++;
    if (data_sram_wen !== 4'hF || data_sram_wdata !== 32'h1122_3344) begin
      n_err++; $display("FAIL sw: wen %b wdata %h", data_sram_wen, data_sram_wdata);
    end
    stall = 6'b001111;
    id_to_ex_bus = mk_bus(32'h99, 32'h0, 12'h002, 3'b001, 4'b0001, 0, 1, 1, 0, 1, 2);
    id_save_bus = 0;
    tick();
    n_vec++;
    if (observed() !== held) begin
      n_err++; $display("FAIL hold: got %h want %h", observed(), held);
    end
    stall = 6'b000111;
    tick();
    n_vec++;
    if (observed() !== 189'b0) begin
      n_err++; $display("FAIL bubble: got %h want 0", observed());
    end
    stall = 0;
  endtask

  task automatic test_reset_hold();
    logic [158:0] nb;
    id_to_ex_bus = mk_bus(32'h80, 32'h0, 12'h001, 3'b001, 4'b0010, 1, 0, 0, 0,
                          32'h3004, 32'h5566_7788);
    id_save_bus = 3'b001;
    tick();
    stall = 6'b001111; rst = 1;
    tick();
    n_vec++;
    if (observed() !== 189'b0 || data_sram_en !== 1'b0) begin
      n_err++; $display("FAIL reset_in_hold: got %h want 0", observed());
    end
    rst = 0; stall = 0;
    nb = mk_bus(32'hC0, 32'h0, 12'h040, 3'b001, 4'b0001, 0, 1, 12, 0, 32'hF0, 32'h0F);
    id_to_ex_bus = nb; id_save_bus = 0;
    tick();
    n_vec++;
    if (ex_to_rf_bus !== {1'b1, 5'd12, 32'hFF}) begin
      n_err++; $display("FAIL release: got %h want %h", ex_to_rf_bus, {1'b1, 5'd12, 32'hFF});
    end
  endtask

  task automatic test_random();
    logic [188:0] exp;
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [11:0] op;
      logic [2:0]  s1;
      logic [3:0]  s2;
      k = $urandom_range(0, 12); op = (k == 12) ? 12'h0 : 12'(1 << k);
      k = $urandom_range(0, 3);  s1 = (k == 3) ? 3'h0 : 3'(1 << k);
      k = $urandom_range(0, 4);  s2 = (k == 4) ? 4'h0 : 4'(1 << k);
      id_to_ex_bus = mk_bus($urandom, $urandom, op, s1, s2, 1'($urandom), 1'($urandom),
                            5'($urandom), 1'($urandom), $urandom, $urandom);
      k = $urandom_range(0, 9);  id_load_bus = (k >= 5) ? 5'h0 : 5'(1 << k);
      k = $urandom_range(0, 5);  id_save_bus = (k >= 3) ? 3'h0 : 3'(1 << k);
      k = $urandom_range(0, 9);
      stall = (k < 6) ? 6'b000000 : (k < 8) ? 6'b001111 : (k < 9) ? 6'b000111 : 6'b111111;
      rst = ($urandom_range(0, 29) == 0);
      tick();
      exp = model(m_bus, m_load, m_save);
      n_vec++;
      if (observed() !== exp) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", i, observed(), exp);
      end
    end
    rst = 0; stall = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1; stall = 0; id_to_ex_bus = '0; id_load_bus = '0; id_save_bus = '0;
    m_bus = '0; m_load = '0; m_save = '0;
    test_reset();
    test_addiu();
    test_shift();
    test_store();
    test_load();
    test_stall();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline; receiving end of the ID→EX bus.
- Registers id_to_ex_bus, id_load_bus and id_save_bus under stall control.
- Computes the ALU result and issues the data SRAM request: byte-lane enables and replicated write data.
- Drives three outputs back to ID: the forwarding bus (ex_to_rf_bus), the load-use hint (pre_inst_is_load), and ex_to_mem_bus onward to MEM.

Parameters:
- None. All widths come from lib/defines.vh.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- stall  in  `StallBus (6)  stall vector; stall[2]=EX input register, stall[3]=MEM input register; `Stop=1
- id_to_ex_bus  in  `ID_TO_EX_WD (159)  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], data1[63:32], data2[31:0]}
- id_load_bus  in  `LoadBus (5)  {lb,lbu,lh,lhu,lw}
- id_save_bus  in  `SaveBus (3)  {sb,sh,sw}
- ex_to_mem_bus  out  `EX_TO_MEM_WD (76)  {pc, ram_en, lane_wen[3:0], sel_rf_res, rf_we, rf_waddr, ex_result}
- ex_load_bus  out  5  registered id_load_bus, for MEM-side extraction
- ex_to_rf_bus  out  `EX_TO_RF_WD (38)  {rf_we, rf_waddr, ex_result}
- pre_inst_is_load  out  1  instruction currently in EX is a load
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  byte-lane write enables
- data_sram_addr  out  32  equals ex_result
- data_sram_wdata  out  32  lane-replicated store data

Behaviour:
- Input register update, priority order, on posedge clk:
  1. rst: clear all registered fields.
  2. stall[2]=Stop and stall[3]=NoStop: clear (inserts a bubble).
  3. stall[2]=NoStop: load id_to_ex_bus, id_load_bus and id_save_bus.
  4. Otherwise: hold.
- A cleared register decodes as a NOP, and all outputs follow. In a NOP, rf_we=0, ram_en=0 and wen=0. This holds after reset.
- All outputs are combinational from the register only (EX latency 1 cycle). No combinational path from ID inputs to outputs.
- src1 is a one-hot select:
  - [0] data1
  - [1] pc
  - [2] {27'b0, inst[10:6]}
  - none selected: 0
- src2 is a one-hot select:
  - [0] data2
  - [1] sign-extended inst[15:0]
  - [2] 32'd8
  - [3] zero-extended inst[15:0]
  - none selected: 0
- alu_op bits [11:0] = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui. Exactly one bit or none; none gives result 0.
- ALU arithmetic:
  - add/sub: 32-bit wrap, no overflow trap.
  - slt: signed compare. sltu: unsigned compare. Both return 0 or 1.
  - Shifts: src2 shifted by src1[4:0]. sra is arithmetic.
  - lui: {src2[15:0], 16'b0}.
- Store lanes: a = ex_result[1:0].
  - sb: wen = 4'b0001<<a, wdata = {4{data2[7:0]}}.
  - sh: wen = a[1] ? 4'b1100 : 4'b0011, wdata = {2{data2[15:0]}}.
  - sw: wen = 4'b1111, wdata = data2; a is ignored (no alignment exception).
- Loads and no-store cases: wen=0, data_sram_en=ram_en.
- On hold the SRAM request is re-driven unchanged. A repeated identical store is accepted as harmless.
- ex_to_rf_bus carries the ALU result even for loads. ID relies on pre_inst_is_load = |ex_load_bus to stall load-use.
- lane_wen in ex_to_mem_bus equals data_sram_wen.
- Reset during a hold or a bubble: rst wins; outputs are NOP on the next cycle.

Decomposition:
- Add to defines.vh:
  - `EX_TO_MEM_WD=76
  - `EX_TO_RF_WD=38
  - ALU op bit indices
  - src-select bit indices
- One sub-module, `alu`: inputs alu_op[11:0], src1, src2; output result[31:0]; purely combinational.
- Lane and wdata generation stays in ex_stage.

Test Plan:
- addiu: data1=0x0000_0010, imm=0xFFFF, src2[1], op add, rf_we=1, waddr=5 → next cycle ex_to_rf_bus={1,5,0x0000_000F}, data_sram_en=0.
- sll: inst[10:6]=4, data2=0x8000_0001, src1[2]/src2[0] → result 0x0000_0010. sra with sa=4 on 0x8000_0000 → 0xF800_0000.
- sb: data1=0x1003, imm=0, data2=0x0000_00AB, ram_en=1, save={1,0,0} → wen=4'b1000, addr=0x1003, wdata=0xABAB_ABAB. sh at 0x1002 → wen=4'b1100.
- lw in EX → pre_inst_is_load=1, ex_load_bus=5'b00001, sel_rf_res=1 in ex_to_mem_bus. Next cycle a NOP loads → pre_inst_is_load=0.
- stall=6'b000111 (stall[2]=1, stall[3]=0) → next cycle all outputs are NOP, rf_we=0, data_sram_en=0. stall=6'b001111 → register holds prior sw; identical wen/addr/wdata re-driven.
- rst asserted for one cycle while holding a store → outputs zero/NOP the next cycle. On release with stall=0, loads the new bus on the first edge.
